// File: rtl/arith_cmd_issuer.sv
// rtl/arith_cmd_issuer.sv - single-outstanding command issuer for a registered arithmetic unit
// Accepts one command, strobes the unit, waits (bounded) for its flag, then holds the response.
module arith_cmd_issuer #(
  parameter int alu_width = 16,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [alu_width-1:0] cmd_a,
  input  logic [alu_width-1:0] cmd_b,
  input  logic [1:0]           cmd_fun,
  output logic [alu_width-1:0] A,
  output logic [alu_width-1:0] B,
  output logic [1:0]           alu_fun,
  output logic                 arith_enable,
  input  logic [alu_width-1:0] arith_out,
  input  logic                 arith_flag,
  input  logic                 carry_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [alu_width-1:0] rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_err,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [alu_width-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0]           fun_q, fun_d;
  logic                 carry_q, carry_d, err_q, err_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 div_zero, timed_out;

  // Divide by zero is answered locally without ever bothering the unit.
  assign div_zero  = (cmd_fun == 2'b11) && (cmd_b == '0);
  assign timed_out = (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = div_zero ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (arith_flag || timed_out) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == IDLE);
    arith_enable = (state_q == ISSUE);
    rsp_valid    = (state_q == RESP);
  end

  always_comb begin
    tmo_d   = tmo_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    data_d  = data_q;
    carry_d = carry_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        a_d   = cmd_a;
        b_d   = cmd_b;
        fun_d = cmd_fun;
        if (div_zero) begin
          data_d  = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
        end
      end
      ISSUE: tmo_d = '0;
      WAIT: begin
        if (arith_flag) begin
          data_d  = arith_out;
          carry_d = carry_out;
          err_d   = 1'b0;
        end else if (timed_out) begin
          data_d  = '0;
          carry_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RESP: if (rsp_ready) cnt_d = cnt_q + 16'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      tmo_q   <= tmo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign alu_fun   = fun_q;
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_arith_cmd_issuer.sv
// tb/tb_arith_cmd_issuer.sv - directed bench for arith_cmd_issuer with a one-cycle registered unit model
module tb_arith_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0, cmd_b = '0;
  logic [1:0]  cmd_fun = '0;
  logic [15:0] A, B;
  logic [1:0]  alu_fun;
  logic        arith_enable;
  logic [15:0] arith_out = '0;
  logic        arith_flag = 1'b0;
  logic        carry_out = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_carry, rsp_err;
  logic [15:0] op_count;
  logic        flag_en = 1'b1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int lat, pulses;

  arith_cmd_issuer #(.alu_width(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
    .A(A), .B(B), .alu_fun(alu_fun), .arith_enable(arith_enable),
    .arith_out(arith_out), .arith_flag(arith_flag), .carry_out(carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Unit model: result and flag appear one cycle after the enable strobe.
  always @(posedge clk) begin
    arith_flag <= arith_enable && flag_en;
    if (arith_enable) begin
      case (alu_fun)
        2'b00: {carry_out, arith_out} <= {1'b0, A} + {1'b0, B};
        2'b01: {carry_out, arith_out} <= {1'b0, A} - {1'b0, B};
        2'b10: begin arith_out <= 16'(A * B); carry_out <= 1'b0; end
        default: begin arith_out <= 16'(A / B); carry_out <= 1'b0; end
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Offer one command, then step edges until rsp_valid (bounded), counting enable pulses.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] fun,
                         output int edges, output int npulse);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_fun = fun;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    edges = 1; npulse = 0;
    while (!rsp_valid && edges < 50) begin
      if (arith_enable) npulse++;
      @(posedge clk); #1;
      edges++;
    end
    check_eq("rsp_valid_seen", rsp_valid, 1);
  endtask

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_enable", arith_enable, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_op_count", op_count, 0);
    check_eq("rst_A", A, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;

    // Reset while in WAIT abandons the command
    flag_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_a = 16'h0011; cmd_b = 16'h0022; cmd_fun = 2'b00;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rstw_cmd_ready", cmd_ready, 1);
    check_eq("rstw_rsp_valid", rsp_valid, 0);
    check_eq("rstw_op_count", op_count, 0);
    check_eq("rstw_A", A, 0);
    repeat (6) @(posedge clk); #1;
    check_eq("rstw_no_rsp", rsp_valid, 0);
    flag_en = 1'b1;

    // Add 5 + 3
    rsp_ready = 1'b1;
    run_cmd(16'h0005, 16'h0003, 2'b00, lat, pulses);
    check_eq("add_latency", lat, 3);
    check_eq("add_pulses", pulses, 1);
    check_eq("add_data", rsp_data, 16'h0008);
    check_eq("add_err", rsp_err, 0);
    check_eq("add_carry", rsp_carry, 0);
    @(posedge clk); #1;
    check_eq("add_op_count", op_count, 1);
    check_eq("add_idle_ready", cmd_ready, 1);
    check_eq("add_data_hold", rsp_data, 16'h0008);
    check_eq("add_valid_low", rsp_valid, 0);

    // Add with carry out: FFFF + 2
    run_cmd(16'hFFFF, 16'h0002, 2'b00, lat, pulses);
    check_eq("addc_data", rsp_data, 16'h0001);
    check_eq("addc_carry", rsp_carry, 1);
    @(posedge clk); #1;
    check_eq("addc_op_count", op_count, 2);

    // Divide by zero bypasses the unit
    run_cmd(16'h0010, 16'h0000, 2'b11, lat, pulses);
    check_eq("div0_latency", lat, 1);
    check_eq("div0_pulses", pulses, 0);
    check_eq("div0_data", rsp_data, 0);
    check_eq("div0_err", rsp_err, 1);
    check_eq("div0_carry", rsp_carry, 0);
    @(posedge clk); #1;
    check_eq("div0_op_count", op_count, 3);

    // Normal divide 0x64 / 7
    run_cmd(16'h0064, 16'h0007, 2'b11, lat, pulses);
    check_eq("div_data", rsp_data, 16'h000E);
    check_eq("div_err", rsp_err, 0);
    @(posedge clk); #1;

    // Sub 3 - 5 with the flag held low: timeout after 4 WAIT cycles
    flag_en = 1'b0;
    run_cmd(16'h0003, 16'h0005, 2'b01, lat, pulses);
    check_eq("tmo_latency", lat, 6);
    check_eq("tmo_pulses", pulses, 1);
    check_eq("tmo_err", rsp_err, 1);
    check_eq("tmo_data", rsp_data, 0);
    @(posedge clk); #1;
    check_eq("tmo_op_count", op_count, 5);
    flag_en = 1'b1;

    // Back-pressure: mul 3 * 7 held for 5 cycles while a new command is offered
    rsp_ready = 1'b0;
    run_cmd(16'h0003, 16'h0007, 2'b10, lat, pulses);
    cmd_valid = 1'b1; cmd_a = 16'h00AA; cmd_b = 16'h00BB; cmd_fun = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", rsp_valid, 1);
      check_eq("stall_data", rsp_data, 16'd21);
      check_eq("stall_carry", rsp_carry, 0);
      check_eq("stall_cmd_ready", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall_op_count", op_count, 6);
    check_eq("stall_A_kept", A, 16'h0003);
    check_eq("stall_idle", cmd_ready, 1);

    // op_count wrap over 65536 back-to-back adds
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("wrap_start", op_count, 0);
    cmd_valid = 1'b1; cmd_a = 16'h0001; cmd_b = 16'h0001; cmd_fun = 2'b00;
    rsp_ready = 1'b1;
    begin
      int n = 0;
      while (op_count !== 16'hFFFF && n < 300000) begin
        @(posedge clk); #1;
        n++;
      end
      check_eq("wrap_ffff", op_count, 16'hFFFF);
      n = 0;
      while (op_count === 16'hFFFF && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check_eq("wrap_zero", op_count, 0);
    end
    cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/arith_cmd_issuer.md
ARITH_CMD_ISSUER -- requirements
Module: arith_cmd_issuer

Interface
REQ-001 SHALL have parameter alu_width, default 16, meaning operand/result width.
REQ-002 SHALL have parameter TIMEOUT, default 4, meaning max WAIT cycles for arith_flag (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 SHALL have ports cmd_a, cmd_b  input  alu_width  operands.
REQ-008 SHALL have port cmd_fun  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-009 SHALL have ports A, B  output  alu_width  operands driven to the arithmetic unit.
REQ-010 SHALL have port alu_fun  output  2  function code driven to the arithmetic unit.
REQ-011 SHALL have port arith_enable  output  1  issue strobe to the arithmetic unit.
REQ-012 SHALL have ports arith_out  input  alu_width, arith_flag  input  1, and carry_out  input  1  registered results from the arithmetic unit.
REQ-013 SHALL have port rsp_valid  output  1  response available.
REQ-014 SHALL have port rsp_ready  input  1  response consumed on a rising edge where rsp_valid and rsp_ready are both high.
REQ-015 SHALL have ports rsp_data  output  alu_width, rsp_carry  output  1, and rsp_err  output  1  result fields.
REQ-016 SHALL have port op_count  output  16  count of completed responses.

Function
REQ-017 SHALL implement an FSM with states IDLE, ISSUE, WAIT, RESP.
REQ-018 SHALL, in IDLE, drive cmd_ready=1; in all other states cmd_ready=0, giving one outstanding command.
REQ-019 SHALL, on acceptance, register cmd_a, cmd_b and cmd_fun; A, B and alu_fun SHALL be driven from these registers and stay stable until the next acceptance.
REQ-020 SHALL, on acceptance with cmd_fun=11 and cmd_b=0, bypass ISSUE and WAIT: go to RESP with rsp_data=0, rsp_carry=0, rsp_err=1.
REQ-021 SHALL, on any other acceptance, go to ISSUE.
REQ-022 SHALL assert arith_enable=1 for exactly the one ISSUE cycle, 0 in every other state, then go to WAIT.
REQ-023 SHALL, in WAIT, sample arith_flag each cycle; when it is 1, capture arith_out into rsp_data and carry_out into rsp_carry, set rsp_err=0, and go to RESP.
REQ-024 SHALL count WAIT cycles; if TIMEOUT cycles elapse with arith_flag=0, go to RESP with rsp_data=0, rsp_carry=0, rsp_err=1.
REQ-025 SHALL, in RESP, hold rsp_valid=1 with rsp_data, rsp_carry and rsp_err stable until rsp_ready=1; on that edge go to IDLE and increment op_count.
REQ-026 SHALL wrap op_count from 16'hFFFF to 0.
REQ-027 SHALL give a nominal latency of 3 edges from acceptance to rsp_valid=1 for a unit whose flag follows enable by one cycle (ISSUE, WAIT, RESP).
REQ-028 SHALL ignore arith_flag outside WAIT.
REQ-029 SHALL ignore cmd_* inputs outside IDLE.
REQ-030 SHALL accept a new command no earlier than the cycle after a response handshake, because IDLE is re-entered first.
REQ-031 SHALL drive rsp_valid=0 and leave rsp_data, rsp_carry and rsp_err holding their last values outside RESP.

Reset
REQ-032 SHALL, when rst=1 at a rising edge, enter IDLE, clear the timeout counter and op_count, and clear the A, B and alu_fun registers and rsp_data, rsp_carry and rsp_err to 0.
REQ-033 SHALL, with rst asserted, give cmd_ready=1 and arith_enable=0, rsp_valid=0 and op_count=0 after the edge.
REQ-034 SHALL, when rst asserts mid-operation in ISSUE, WAIT or RESP, abandon the pending command without producing a response or incrementing op_count.
REQ-035 SHALL take priority of rst over every handshake in the same cycle.

Verification
REQ-036 SHALL be verified with: add A=16'h0005, B=16'h0003, unit flag one cycle after enable, rsp_ready=1 -> one arith_enable pulse, rsp_valid on the 3rd edge, rsp_data=16'h0008, rsp_err=0, op_count=1.
REQ-037 SHALL be verified with: div A=16'h0010, B=0 -> no arith_enable pulse, rsp_valid on the next edge, rsp_data=0, rsp_err=1.
REQ-038 SHALL be verified with: sub A=3, B=5 and arith_flag held 0, TIMEOUT=4 -> after 4 WAIT cycles rsp_err=1, rsp_data=0.
REQ-039 SHALL be verified with: a response while rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_carry stable throughout, cmd_ready=0, a new cmd_valid is not accepted.
REQ-040 SHALL be verified with: rst=1 during WAIT -> next edge in IDLE, cmd_ready=1, no response, op_count unchanged at 0.
REQ-041 SHALL be verified with: 65536 back-to-back adds -> op_count wraps to 0.
